// File: rtl/sys_wrapper_core.sv
// Hyperspectral per-pixel ACE-style target detector with AXI4-Lite coefficient load.
// Optional macro SYS_DEBUG_OUT_EN adds the DEBUG bit that selects the raw matched-filter output.
module sys_wrapper_core #(
    parameter int unsigned PIXEL_DATA_WIDTH = 16,
    parameter int unsigned BRAM_DATA_WIDTH  = 32,
    parameter int unsigned NUM_BANDS        = 16,
    parameter int unsigned OUT_DATA_WIDTH   = 32,
    parameter int unsigned FRAC_BITS        = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [3:0]                  s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [31:0]                 s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [3:0]                  s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [31:0]                 s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    input  logic [PIXEL_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    input  logic                        S_AXIS_tlast,
    output logic                        S_AXIS_tready,
    output logic [OUT_DATA_WIDTH-1:0]   M_AXIS_DOUT_tdata,
    output logic                        M_AXIS_DOUT_tvalid,
    output logic                        M_AXIS_DOUT_tlast,
    input  logic                        M_AXIS_DOUT_tready
);

    localparam int unsigned NN = NUM_BANDS * NUM_BANDS;
    localparam int unsigned MW = $clog2(NN);
    localparam int unsigned BW = $clog2(NUM_BANDS);
    localparam int unsigned JW = $clog2(NUM_BANDS + 1);
    localparam int unsigned DW = 64;
    localparam int unsigned QW = 72;
    localparam logic signed [DW-1:0] D_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [DW-1:0] D_MIN = 64'shFFFF_FFFF_8000_0000;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_QUAD, S_CMP, S_OUT} state_t;

    state_t state, state_next;
    logic   tready_next;

    logic signed [BRAM_DATA_WIDTH-1:0] m_mem  [NN];
    logic signed [BRAM_DATA_WIDTH-1:0] sr_mem [NUM_BANDS];
    logic [PIXEL_DATA_WIDTH-1:0]       x_buf  [NUM_BANDS];
    logic [31:0]                       srs;
    logic [MW-1:0]                     ptr_m;
    logic [BW-1:0]                     ptr_s;
    logic                              debug;

    logic [BW-1:0]         band;
    logic                  last_seen;
    logic [BW-1:0]         i_cnt;
    logic [JW-1:0]         j_cnt;
    logic signed [DW-1:0]  d_acc;
    logic signed [QW-1:0]  t_acc;
    logic signed [QW-1:0]  q_acc;

    logic                  wr_fire, ar_fire, beat_fire, beat_last, quad_done, out_fire;
    logic [MW-1:0]         m_idx;
    logic signed [DW-1:0]  d_prod;
    logic signed [QW-1:0]  m_prod, fold_prod;
    logic signed [DW-1:0]  d_sh, d_sq;
    logic signed [QW-1:0]  q_sh;
    logic [31:0]           d_s, q_s, rd_mux;
    logic [63:0]           thr;
    logic                  detect;
    logic [OUT_DATA_WIDTH-1:0] result_c;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    assign wr_fire   = s_axi_awready & s_axi_awvalid & s_axi_wready & s_axi_wvalid;
    assign ar_fire   = s_axi_arready & s_axi_arvalid;
    assign beat_fire = S_AXIS_tvalid & S_AXIS_tready;
    assign beat_last = (band == BW'(NUM_BANDS - 1));
    assign quad_done = (state == S_QUAD) && (i_cnt == BW'(NUM_BANDS - 1)) && (j_cnt == JW'(NUM_BANDS));
    assign out_fire  = M_AXIS_DOUT_tvalid & M_AXIS_DOUT_tready;

    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
        end
        return r;
    endfunction

    // AXI-Lite write handshake: one accept per response, response held until bready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
            s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
            if (wr_fire)           s_axi_bvalid <= 1'b1;
            else if (s_axi_bready) s_axi_bvalid <= 1'b0;
        end
    end

    // Coefficient storage and auto-incrementing load pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < int'(NN); k++)        m_mem[k]  <= '0;
            for (int k = 0; k < int'(NUM_BANDS); k++) sr_mem[k] <= '0;
            srs   <= '0;
            ptr_m <= '0;
            ptr_s <= '0;
            debug <= 1'b0;
        end else if (wr_fire) begin
            case (s_axi_awaddr[3:2])
                2'd0: begin
                    m_mem[ptr_m] <= strb_merge(m_mem[ptr_m], s_axi_wdata, s_axi_wstrb);
                    ptr_m <= (ptr_m == MW'(NN - 1)) ? '0 : ptr_m + MW'(1);
                end
                2'd1: begin
                    sr_mem[ptr_s] <= strb_merge(sr_mem[ptr_s], s_axi_wdata, s_axi_wstrb);
                    ptr_s <= (ptr_s == BW'(NUM_BANDS - 1)) ? '0 : ptr_s + BW'(1);
                end
                2'd2: srs <= strb_merge(srs, s_axi_wdata, s_axi_wstrb);
                default: begin
                    ptr_m <= '0;
                    ptr_s <= '0;
`ifdef SYS_DEBUG_OUT_EN
                    if (s_axi_wstrb[0]) debug <= s_axi_wdata[0];
`else
                    debug <= 1'b0;
`endif
                end
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr[3:2])
            2'd0:    rd_mux = 32'(ptr_m);
            2'd1:    rd_mux = 32'(ptr_s);
            2'd2:    rd_mux = srs;
            default: rd_mux = {31'b0, debug};
        endcase
    end

    // AXI-Lite read: capture on address accept, hold until rready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= s_axi_arvalid & ~s_axi_arready & ~s_axi_rvalid;
            if (ar_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // MAC operands; pixel samples are unsigned so they get a zero sign bit
    always_comb begin
        m_idx     = MW'(i_cnt) * MW'(NUM_BANDS) + MW'(j_cnt);
        d_prod    = DW'(sr_mem[band]) * DW'($signed({1'b0, S_AXIS_tdata}));
        m_prod    = QW'(m_mem[m_idx]) * QW'($signed({1'b0, x_buf[j_cnt[BW-1:0]]}));
        fold_prod = t_acc * QW'($signed({1'b0, x_buf[i_cnt]}));
    end

    // Saturation and ACE-style decision
    always_comb begin
        d_sh = d_acc >>> FRAC_BITS;
        q_sh = q_acc >>> FRAC_BITS;
        if (d_sh > D_MAX)      d_s = 32'h7FFF_FFFF;
        else if (d_sh < D_MIN) d_s = 32'h8000_0000;
        else                   d_s = d_sh[31:0];
        if (q_sh[QW-1])           q_s = '0;
        else if (|q_sh[QW-1:32])  q_s = '1;
        else                      q_s = q_sh[31:0];
        d_sq   = DW'($signed(d_s)) * DW'($signed(d_s));
        thr    = (64'(srs) * 64'(q_s)) >> 1;
        detect = $unsigned(d_sq) > thr;
`ifdef SYS_DEBUG_OUT_EN
        result_c = debug ? OUT_DATA_WIDTH'(d_s) : OUT_DATA_WIDTH'(detect);
`else
        result_c = OUT_DATA_WIDTH'(detect);
`endif
    end

    // Pixel capture, quadratic-form sequencing and output register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < int'(NUM_BANDS); k++) x_buf[k] <= '0;
            band               <= '0;
            last_seen          <= 1'b0;
            d_acc              <= '0;
            t_acc              <= '0;
            q_acc              <= '0;
            i_cnt              <= '0;
            j_cnt              <= '0;
            M_AXIS_DOUT_tdata  <= '0;
            M_AXIS_DOUT_tvalid <= 1'b0;
            M_AXIS_DOUT_tlast  <= 1'b0;
        end else begin
            if (beat_fire) begin
                x_buf[band] <= S_AXIS_tdata;
                d_acc       <= (band == '0) ? d_prod : d_acc + d_prod;
                last_seen   <= (band == '0) ? S_AXIS_tlast : (last_seen | S_AXIS_tlast);
                band        <= beat_last ? '0 : band + BW'(1);
                if (beat_last) begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                    t_acc <= '0;
                    q_acc <= '0;
                end
            end
            if (state == S_QUAD) begin
                if (j_cnt == JW'(NUM_BANDS)) begin
                    q_acc <= q_acc + fold_prod;
                    t_acc <= '0;
                    j_cnt <= '0;
                    i_cnt <= i_cnt + BW'(1);
                end else begin
                    t_acc <= t_acc + m_prod;
                    j_cnt <= j_cnt + JW'(1);
                end
            end
            if (state == S_CMP) begin
                M_AXIS_DOUT_tdata  <= result_c;
                M_AXIS_DOUT_tlast  <= last_seen;
                M_AXIS_DOUT_tvalid <= 1'b1;
            end else if (out_fire) begin
                M_AXIS_DOUT_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            S_AXIS_tready <= 1'b0;
        end else begin
            state         <= state_next;
            S_AXIS_tready <= tready_next;
        end
    end

    always_comb begin
        state_next  = state;
        tready_next = 1'b0;
        case (state)
            S_IDLE:  if (beat_fire) state_next = beat_last ? S_QUAD : S_LOAD;
            S_LOAD:  if (beat_fire && beat_last) state_next = S_QUAD;
            S_QUAD:  if (quad_done) state_next = S_CMP;
            S_CMP:   state_next = S_OUT;
            S_OUT:   if (out_fire) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        tready_next = (state_next == S_IDLE) || (state_next == S_LOAD);
    end

endmodule

// File: tb/tb_sys_wrapper_core.sv
// Directed bench for sys_wrapper_core: register map, detection results, backpressure and reset abort.
`timescale 1ns/1ps
module tb_sys_wrapper_core;
    localparam int unsigned NB = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [15:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid, S_AXIS_tlast, S_AXIS_tready;
    logic [31:0] M_AXIS_DOUT_tdata;
    logic        M_AXIS_DOUT_tvalid, M_AXIS_DOUT_tlast, M_AXIS_DOUT_tready;

    always #5 clk = ~clk;

    sys_wrapper_core dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tlast(S_AXIS_tlast),
        .S_AXIS_tready(S_AXIS_tready), .M_AXIS_DOUT_tdata(M_AXIS_DOUT_tdata),
        .M_AXIS_DOUT_tvalid(M_AXIS_DOUT_tvalid), .M_AXIS_DOUT_tlast(M_AXIS_DOUT_tlast),
        .M_AXIS_DOUT_tready(M_AXIS_DOUT_tready)
    );

    int          tests = 0;
    int          fails = 0;
    int          outs  = 0;
    logic [32:0] sb [$];
    int          mdl_m  [NB*NB];
    int          mdl_sr [NB];
    logic [31:0] mdl_srs;
    logic        mdl_dbg;
    logic [15:0] px [NB];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result for the pixel currently in px[]
    function automatic logic [32:0] model(input logic last);
        longint             d, dsh, sd;
        logic signed [71:0] q, t, qsh;
        logic [31:0]        ds, qs;
        logic [63:0]        dd, thr;
        logic               det;
        d = 0;
        for (int b = 0; b < int'(NB); b++) d += longint'(mdl_sr[b]) * longint'(px[b]);
        q = '0;
        for (int i = 0; i < int'(NB); i++) begin
            t = '0;
            for (int j = 0; j < int'(NB); j++) t += 72'(mdl_m[i*NB+j]) * 72'(px[j]);
            q += t * 72'(px[i]);
        end
        dsh = d >>> 16;
        if (dsh > 64'sh7FFF_FFFF)        ds = 32'h7FFF_FFFF;
        else if (dsh < -64'sh8000_0000)  ds = 32'h8000_0000;
        else                             ds = dsh[31:0];
        qsh = q >>> 16;
        if (qsh < 0)                       qs = 32'h0;
        else if (qsh > 72'sh0_FFFF_FFFF)   qs = 32'hFFFF_FFFF;
        else                               qs = qsh[31:0];
        sd  = longint'(int'(ds));
        dd  = sd * sd;
        thr = ({32'b0, mdl_srs} * {32'b0, qs}) >> 1;
        det = dd > thr;
        return {last, mdl_dbg ? ds : {31'b0, det}};
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata = d; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("awready_timeout", s_axi_awready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("bvalid_timeout", s_axi_bvalid, 1);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("arready_timeout", s_axi_arready, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("rvalid_timeout", s_axi_rvalid, 1);
        d = s_axi_rdata;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic set_dbg(input logic v);
        axi_write(4'hC, {31'b0, v});
`ifdef SYS_DEBUG_OUT_EN
        mdl_dbg = v;
`else
        mdl_dbg = 1'b0;
`endif
    endtask

    task automatic set_srs(input logic [31:0] v);
        axi_write(4'h8, v);
        mdl_srs = v;
    endtask

    task automatic load_sr(input int v);
        axi_write(4'hC, {31'b0, mdl_dbg});
        for (int b = 0; b < int'(NB); b++) begin
            axi_write(4'h4, v);
            mdl_sr[b] = v;
        end
    endtask

    task automatic load_identity();
        axi_write(4'hC, {31'b0, mdl_dbg});
        for (int k = 0; k < int'(NB*NB); k++) begin
            mdl_m[k] = (k / NB == k % NB) ? 32'h0001_0000 : 0;
            axi_write(4'h0, mdl_m[k]);
        end
    endtask

    task automatic send_beat(input logic [15:0] v, input logic l);
        int n;
        S_AXIS_tdata = v; S_AXIS_tlast = l; S_AXIS_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!S_AXIS_tready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) check("s_tready_timeout", S_AXIS_tready, 1);
        @(posedge clk); #1;
        S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
    endtask

    task automatic send_pixel(input logic last);
        for (int b = 0; b < int'(NB); b++) send_beat(px[b], last && (b == int'(NB) - 1));
    endtask

    task automatic fill_px(input int v);
        for (int b = 0; b < int'(NB); b++) px[b] = (v < 0) ? 16'($urandom_range(0, 65535)) : 16'(v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard consumer: every accepted result must match the oldest expectation
    always @(negedge clk) begin
        if (resetn && M_AXIS_DOUT_tvalid && M_AXIS_DOUT_tready) begin
            logic [32:0] e;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL out_unexpected: observed %0h expected no output", M_AXIS_DOUT_tdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_tdata", M_AXIS_DOUT_tdata, e[31:0]);
                check("out_tlast", M_AXIS_DOUT_tlast, e[32]);
            end
            outs++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [32:0] e;
        int          n, outs0;
        resetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
        S_AXIS_tdata = '0; S_AXIS_tvalid = 0; S_AXIS_tlast = 0; M_AXIS_DOUT_tready = 1'b1;
        mdl_srs = '0; mdl_dbg = 1'b0;
        for (int k = 0; k < int'(NB*NB); k++) mdl_m[k] = 0;
        for (int b = 0; b < int'(NB); b++) mdl_sr[b] = 0;

        @(negedge clk); @(negedge clk);
        check("rst_s_tready", S_AXIS_tready, 0);
        check("rst_m_tvalid", M_AXIS_DOUT_tvalid, 0);
        check("rst_m_tdata", M_AXIS_DOUT_tdata, 0);
        check("rst_m_tlast", M_AXIS_DOUT_tlast, 0);
        check("rst_awready", s_axi_awready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Register map and pointer behaviour
        axi_read(4'h0, rd); check("ptrm_reset", rd, 0);
        for (int k = 0; k < 3; k++) axi_write(4'h0, 32'h1234);
        axi_read(4'h0, rd); check("ptrm_3", rd, 3);
        for (int k = 0; k < 2; k++) axi_write(4'h4, 32'h5678);
        axi_read(4'h4, rd); check("ptrs_2", rd, 2);
        axi_write(4'hC, 32'h0);
        axi_read(4'h0, rd); check("ptrm_clr", rd, 0);
        axi_read(4'h4, rd); check("ptrs_clr", rd, 0);
        for (int k = 0; k < int'(NB*NB); k++) axi_write(4'h0, 32'h0);
        axi_read(4'h0, rd); check("ptrm_wrap", rd, 0);
        set_dbg(1'b1);
        axi_read(4'hC, rd); check("debug_rd", rd, {31'b0, mdl_dbg});
        set_dbg(1'b0);
        axi_read(4'hC, rd); check("debug_rd0", rd, 0);

        // Identity M, unit sR
        load_identity();
        load_sr(32'h0001_0000);
        set_srs(32'd16);
        axi_read(4'h8, rd); check("srs_rd", rd, 16);

        fill_px(1); sb.push_back(33'h0_0000_0001); send_pixel(1'b0); drain();
        set_dbg(1'b1);
`ifdef SYS_DEBUG_OUT_EN
        sb.push_back(33'h0_0000_0010);
`else
        sb.push_back(33'h0_0000_0001);
`endif
        send_pixel(1'b0); drain();
        set_dbg(1'b0);
        fill_px(100); sb.push_back(33'h0_0000_0001); send_pixel(1'b0); drain();
        set_srs(32'd64); sb.push_back(33'h0_0000_0000); send_pixel(1'b0); drain();
        set_srs(32'd16);
        for (int r = 0; r < 3; r++) begin
            fill_px(-1); sb.push_back(model(1'b0)); send_pixel(1'b0); drain();
        end

        // Output backpressure: result and tlast must hold while the stream stays blocked
        M_AXIS_DOUT_tready = 1'b0;
        fill_px(-1); e = model(1'b1); sb.push_back(e); send_pixel(1'b1);
        n = 0;
        while (!M_AXIS_DOUT_tvalid && n < 1000) begin @(negedge clk); n++; end
        check("stall_tvalid", M_AXIS_DOUT_tvalid, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("stall_tdata", M_AXIS_DOUT_tdata, e[31:0]);
            check("stall_tlast", M_AXIS_DOUT_tlast, e[32]);
            check("stall_s_tready", S_AXIS_tready, 0);
        end
        @(posedge clk); #1;
        M_AXIS_DOUT_tready = 1'b1;
        drain();

        // Back-to-back pixels, tlast only on the second
        fill_px(-1); sb.push_back(model(1'b0)); send_pixel(1'b0);
        fill_px(-1); sb.push_back(model(1'b1)); send_pixel(1'b1);
        drain();

        // Zero sR gives no detection and zero raw output
        load_sr(0);
        fill_px(-1); sb.push_back(33'h0_0000_0000); send_pixel(1'b0); drain();
        set_dbg(1'b1); sb.push_back(33'h0_0000_0000); send_pixel(1'b0); drain();
        set_dbg(1'b0);

        // Reset in the middle of a pixel aborts it
        fill_px(1);
        for (int b = 0; b < 6; b++) send_beat(px[b], 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_s_tready", S_AXIS_tready, 0);
        check("midrst_m_tvalid", M_AXIS_DOUT_tvalid, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mdl_srs = '0; mdl_dbg = 1'b0;
        for (int b = 0; b < int'(NB); b++) mdl_sr[b] = 0;
        axi_read(4'h8, rd); check("midrst_srs", rd, 0);
        load_identity();
        load_sr(32'h0001_0000);
        set_srs(32'd16);
        outs0 = outs;
        fill_px(1); sb.push_back(33'h0_0000_0001); send_pixel(1'b0); drain();
        repeat (50) @(negedge clk);
        check("midrst_out_count", 64'(outs - outs0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
